// File: rtl/glyph_rect_sequencer_pkg.sv
// glyph_rect_sequencer_pkg: glyph codes, rectangle-count table and shared types
package glyph_rect_sequencer_pkg;
  localparam int GLYPH_I = 1;
  localparam int GLYPH_U = 2;
  localparam int GLYPH_G = 3;
  localparam int MAX_RECTS = 4;
  localparam int R_W = $clog2(MAX_RECTS);
  localparam int CNT_W = $clog2(MAX_RECTS + 1);
  typedef enum logic [1:0] {IDLE, EMIT, FIN} state_e;
  typedef struct packed {
    logic [2:0] x1;
    logic [2:0] y1;
    logic [2:0] x2;
    logic [2:0] y2;
  } urect_t;
  // Strokes per glyph; unknown codes draw nothing, like blank.
  function automatic logic [CNT_W-1:0] rect_count(input int code);
    return code == GLYPH_I ? CNT_W'(1) : code == GLYPH_U ? CNT_W'(3) :
           code == GLYPH_G ? CNT_W'(4) : CNT_W'(0);
  endfunction
endpackage

// File: rtl/glyph_rom.sv
// glyph_rom: combinational unit-grid stroke table indexed by glyph code and stroke number
// Ports: code_i glyph code, r_i stroke index; rect_o unit-grid corners, count_o strokes in glyph.
module glyph_rom
  import glyph_rect_sequencer_pkg::*;
#(
  parameter int CODE_W = 2
) (
  input  logic [CODE_W-1:0] code_i,
  input  logic [R_W-1:0]    r_i,
  output urect_t            rect_o,
  output logic [CNT_W-1:0]  count_o
);
  always_comb begin
    rect_o = '0;
    count_o = rect_count(int'(code_i));
    if (int'(code_i) == GLYPH_I)
      rect_o = {3'd0, 3'd0, 3'd1, 3'd3};
    else if (int'(code_i) == GLYPH_U)
      rect_o = r_i == 2'd0 ? {3'd0, 3'd0, 3'd1, 3'd4} :
               r_i == 2'd1 ? {3'd2, 3'd0, 3'd3, 3'd4} : {3'd1, 3'd3, 3'd2, 3'd4};
    else if (int'(code_i) == GLYPH_G)
      rect_o = r_i == 2'd0 ? {3'd0, 3'd0, 3'd3, 3'd1} :
               r_i == 2'd1 ? {3'd0, 3'd1, 3'd1, 3'd4} :
               r_i == 2'd2 ? {3'd1, 3'd3, 3'd3, 3'd4} : {3'd2, 3'd2, 3'd3, 3'd3};
  end
endmodule

// File: rtl/glyph_rect_sequencer.sv
// glyph_rect_sequencer: streams scaled stroke rectangles for every letter of a glyph string
// Ports: clock_i/reset_i (sync, active-high); start_i latches origin_*_i, text_i, num_letters_i when idle;
// rect_valid_o/rect_ready_i handshake carrying rect_{x1,y1,x2,y2}_o (x2/y2 exclusive) and rect_last_o;
// busy_o while a string is in flight, done_o one-cycle pulse at the end.
module glyph_rect_sequencer
  import glyph_rect_sequencer_pkg::*;
#(
  parameter int UNIT = 32,
  parameter int ADV = 4,
  parameter int MAX_LETTERS = 8,
  parameter int CODE_W = 2,
  parameter int LEN_W = 4
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic [31:0]                   origin_x_i,
  input  logic [31:0]                   origin_y_i,
  input  logic [MAX_LETTERS*CODE_W-1:0] text_i,
  input  logic [LEN_W-1:0]              num_letters_i,
  output logic                          busy_o,
  output logic                          rect_valid_o,
  input  logic                          rect_ready_i,
  output logic [31:0]                   rect_x1_o,
  output logic [31:0]                   rect_y1_o,
  output logic [31:0]                   rect_x2_o,
  output logic [31:0]                   rect_y2_o,
  output logic                          rect_last_o,
  output logic                          done_o
);
  localparam logic [31:0] STEP = 32'(ADV * UNIT);
  localparam logic [31:0] CELL = 32'(UNIT);
  state_e state_q, state_d;
  logic [31:0] ox_q, ox_d, oy_q, oy_d;
  logic [MAX_LETTERS*CODE_W-1:0] text_q, text_d;
  logic [LEN_W-1:0] len_q, len_d, k_q, k_d, lastk_q, lastk_d, len_in, lastk_in;
  logic [R_W-1:0] r_q, r_d;
  logic [CODE_W-1:0] code;
  urect_t ur;
  logic [CNT_W-1:0] cnt;
  logic valid, xfer, r_end, letter_end;
  assign len_in = num_letters_i > LEN_W'(MAX_LETTERS) ? LEN_W'(MAX_LETTERS) : num_letters_i;
  // Last non-blank letter, found at latch time so rect_last can fire before trailing blanks.
  always_comb begin
    lastk_in = '0;
    for (int i = 0; i < MAX_LETTERS; i++)
      if (i < int'(len_in) && rect_count(int'(text_i[i*CODE_W +: CODE_W])) != '0)
        lastk_in = LEN_W'(i);
  end
  assign code = text_q[k_q*CODE_W +: CODE_W];
  glyph_rom #(.CODE_W(CODE_W)) u_rom (
    .code_i (code),
    .r_i    (r_q),
    .rect_o (ur),
    .count_o(cnt)
  );
  assign valid = state_q == EMIT && cnt != '0;
  assign xfer = valid && rect_ready_i;
  assign r_end = CNT_W'(r_q) == cnt - CNT_W'(1);
  // Blank letters end immediately, giving their one dead cycle.
  assign letter_end = state_q == EMIT && (cnt == '0 || (xfer && r_end));
  always_comb begin
    state_d = state_q;
    ox_d = ox_q;
    oy_d = oy_q;
    text_d = text_q;
    len_d = len_q;
    lastk_d = lastk_q;
    k_d = k_q;
    r_d = r_q;
    if (state_q == IDLE && start_i) begin
      ox_d = origin_x_i;
      oy_d = origin_y_i;
      text_d = text_i;
      len_d = len_in;
      lastk_d = lastk_in;
      k_d = '0;
      r_d = '0;
      state_d = len_in == '0 ? FIN : EMIT;
    end else if (letter_end) begin
      k_d = k_q + LEN_W'(1);
      r_d = '0;
      state_d = k_q == len_q - LEN_W'(1) ? FIN : EMIT;
    end else if (xfer) begin
      r_d = r_q + R_W'(1);
    end else if (state_q == FIN) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ox_q <= '0;
      oy_q <= '0;
      text_q <= '0;
      len_q <= '0;
      lastk_q <= '0;
      k_q <= '0;
      r_q <= '0;
    end else begin
      state_q <= state_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
      text_q <= text_d;
      len_q <= len_d;
      lastk_q <= lastk_d;
      k_q <= k_d;
      r_q <= r_d;
    end
  end
  assign rect_valid_o = valid;
  assign rect_x1_o = valid ? ox_q + 32'(k_q) * STEP + 32'(ur.x1) * CELL : '0;
  assign rect_x2_o = valid ? ox_q + 32'(k_q) * STEP + 32'(ur.x2) * CELL : '0;
  assign rect_y1_o = valid ? oy_q + 32'(ur.y1) * CELL : '0;
  assign rect_y2_o = valid ? oy_q + 32'(ur.y2) * CELL : '0;
  assign rect_last_o = valid && k_q == lastk_q && r_end;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == FIN;
endmodule

// File: tb/tb_glyph_rect_sequencer.sv
// tb_glyph_rect_sequencer: directed scenario bench for glyph_rect_sequencer
module tb_glyph_rect_sequencer;
  logic clk = 1'b0;
  logic rst, start, ready;
  logic [31:0] ox, oy;
  logic [15:0] text;
  logic [3:0] num;
  logic busy, valid, last, done;
  logic [31:0] x1, y1, x2, y2;
  int pass_cnt = 0;
  int tot_cnt = 0;
  logic [127:0] exp_iu [4] = '{
    {32'd100, 32'd50, 32'd132, 32'd146},
    {32'd228, 32'd50, 32'd260, 32'd178},
    {32'd292, 32'd50, 32'd324, 32'd178},
    {32'd260, 32'd146, 32'd292, 32'd178}};
  logic [127:0] exp_g [4] = '{
    {32'd10, 32'd20, 32'd106, 32'd52},
    {32'd10, 32'd52, 32'd42, 32'd148},
    {32'd42, 32'd116, 32'd106, 32'd148},
    {32'd74, 32'd84, 32'd106, 32'd116}};
  wire [129:0] obs = {valid, x1, y1, x2, y2, last};
  always #5 clk = ~clk;
  glyph_rect_sequencer dut (
    .clock_i(clk), .reset_i(rst), .start_i(start),
    .origin_x_i(ox), .origin_y_i(oy), .text_i(text), .num_letters_i(num),
    .busy_o(busy), .rect_valid_o(valid), .rect_ready_i(ready),
    .rect_x1_o(x1), .rect_y1_o(y1), .rect_x2_o(x2), .rect_y2_o(y2),
    .rect_last_o(last), .done_o(done)
  );
  task automatic do_start(input logic [31:0] x, input logic [31:0] y, input logic [15:0] t, input logic [3:0] n);
    @(negedge clk);
    ox = x; oy = y; text = t; num = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1; start = 1'b0; ready = 1'b1; ox = '0; oy = '0; text = '0; num = '0;
    repeat (2) @(negedge clk);
    tot_cnt++;
    if ({busy, done, obs} !== '0) $display("FAIL reset_state: got %h required 0", {busy, done, obs});
    else pass_cnt++;
    rst = 1'b0;
  endtask
  task automatic test_basic;
    ready = 1'b1;
    do_start(100, 50, 16'h0009, 2);
    for (int i = 0; i < 4; i++) begin
      tot_cnt++;
      if (obs !== {1'b1, exp_iu[i], i == 3}) $display("FAIL basic_rect%0d: got %h required %h", i, obs, {1'b1, exp_iu[i], i == 3});
      else pass_cnt++;
      @(negedge clk);
    end
    tot_cnt++;
    if ({busy, done, valid} !== 3'b110) $display("FAIL basic_done: got %b required 110", {busy, done, valid});
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if ({busy, done, valid} !== 3'b000) $display("FAIL basic_idle: got %b required 000", {busy, done, valid});
    else pass_cnt++;
  endtask
  task automatic test_backpressure;
    int idx = 0;
    ready = 1'b1;
    do_start(100, 50, 16'h0009, 2);
    for (int c = 0; c < 12 && idx < 4; c++) begin
      ready = !(c >= 1 && c <= 3);
      tot_cnt++;
      if (obs !== {1'b1, exp_iu[idx], idx == 3}) $display("FAIL bp_cycle%0d: got %h required %h", c, obs, {1'b1, exp_iu[idx], idx == 3});
      else pass_cnt++;
      @(posedge clk);
      if (ready) idx++;
      @(negedge clk);
    end
    ready = 1'b1;
    tot_cnt++;
    if ({idx == 4, done} !== 2'b11) $display("FAIL bp_done: got idx=%0d done=%b required idx=4 done=1", idx, done);
    else pass_cnt++;
    @(negedge clk);
  endtask
  task automatic test_empty_clamp;
    int cnt = 0;
    int lcnt = 0;
    logic [31:0] lx = '0;
    ready = 1'b1;
    do_start(0, 0, 16'h5555, 0);
    tot_cnt++;
    if ({busy, done, valid} !== 3'b110) $display("FAIL empty_done: got %b required 110", {busy, done, valid});
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if ({busy, done, valid} !== 3'b000) $display("FAIL empty_idle: got %b required 000", {busy, done, valid});
    else pass_cnt++;
    do_start(0, 0, 16'h5555, 15);
    for (int c = 0; c < 40 && !done; c++) begin
      if (valid) begin
        cnt++;
        if (last) begin
          lcnt++;
          lx = x1;
        end
      end
      @(negedge clk);
    end
    tot_cnt++;
    if ({done, 8'(cnt), 8'(lcnt), lx} !== {1'b1, 8'd8, 8'd1, 32'd896})
      $display("FAIL clamp: got done=%b rects=%0d lasts=%0d last_x1=%0d required 1/8/1/896", done, cnt, lcnt, lx);
    else pass_cnt++;
    @(negedge clk);
  endtask
  task automatic test_g_blank;
    ready = 1'b1;
    do_start(10, 20, 16'h0003, 3);
    for (int i = 0; i < 4; i++) begin
      tot_cnt++;
      if (obs !== {1'b1, exp_g[i], i == 3}) $display("FAIL g_rect%0d: got %h required %h", i, obs, {1'b1, exp_g[i], i == 3});
      else pass_cnt++;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      tot_cnt++;
      if ({valid, done, busy} !== {1'b0, i == 2, 1'b1}) $display("FAIL g_tail%0d: got %b required %b", i, {valid, done, busy}, {1'b0, i == 2, 1'b1});
      else pass_cnt++;
      @(negedge clk);
    end
  endtask
  task automatic test_wrap;
    ready = 1'b1;
    do_start(32'hFFFF_FFF0, 0, 16'h0001, 1);
    tot_cnt++;
    if (obs !== {1'b1, 32'hFFFF_FFF0, 32'd0, 32'h0000_0010, 32'd96, 1'b1}) $display("FAIL wrap: got %h", obs);
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if (done !== 1'b1) $display("FAIL wrap_done: got %b required 1", done);
    else pass_cnt++;
    @(negedge clk);
  endtask
  task automatic test_reset_mid;
    ready = 1'b1;
    do_start(100, 50, 16'h0009, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tot_cnt++;
    if ({busy, done, obs} !== '0) $display("FAIL midreset: got %h required 0", {busy, done, obs});
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    tot_cnt++;
    if ({busy, done, valid} !== 3'b000) $display("FAIL midreset_nodone: got %b required 000", {busy, done, valid});
    else pass_cnt++;
  endtask
  task automatic test_back_to_back;
    ready = 1'b0;
    do_start(100, 50, 16'h0009, 2);
    tot_cnt++;
    if (obs !== {1'b1, exp_iu[0], 1'b0}) $display("FAIL b2b_first: got %h", obs);
    else pass_cnt++;
    ox = 5; oy = 7; text = '0; num = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tot_cnt++;
    if ({busy, obs} !== {1'b1, 1'b1, exp_iu[0], 1'b0}) $display("FAIL b2b_ignored: got %h", {busy, obs});
    else pass_cnt++;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tot_cnt++;
      if (obs !== {1'b1, exp_iu[i], i == 3}) $display("FAIL b2b_rect%0d: got %h required %h", i, obs, {1'b1, exp_iu[i], i == 3});
      else pass_cnt++;
      @(negedge clk);
    end
    tot_cnt++;
    if (done !== 1'b1) $display("FAIL b2b_done: got %b required 1", done);
    else pass_cnt++;
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_clamp();
    test_g_blank();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
